icache_dm: RTL and testbench



---
 rtl/icache_dm_pkg.sv | 19 +
 rtl/icache_line_ram.sv | 31 +++
 rtl/icache_dm.sv | 128 ++++++++++++
 tb/tb_icache_dm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared ISA package: the instruction word type plus the direct-mapped I-cache
// FSM state and address-field types (sized for the default geometry).
package riscv_isa;

    typedef logic [31:0] INSTRUCTION;

    localparam int ICACHE_LINES = 16;
    localparam int ICACHE_WORDS = 4;
    localparam int ICACHE_OFF_W = $clog2(ICACHE_WORDS);
    localparam int ICACHE_IDX_W = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - ICACHE_OFF_W - 2;

    typedef logic [ICACHE_OFF_W-1:0] icache_offset_t;
    typedef logic [ICACHE_IDX_W-1:0] icache_index_t;
    typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} ICACHE_STATE;

endpackage

// File: rtl/icache_line_ram.sv
// Data array of the I-cache: synchronous write by {index,word}, registered read
// by {index,offset}. Only the read register is reset so instruction starts at 0.
module icache_line_ram
    import riscv_isa::*;
#(
    parameter int AW = ICACHE_IDX_W + ICACHE_OFF_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    INSTRUCTION mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with line refill over a req/resp memory port.
// Optional hit/miss counters are compiled in with `define ICACHE_STATS_EN.
module icache_dm
    import riscv_isa::*;
#(
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    output logic [31:0] instruction,
    output logic        valid,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(LINES);
    localparam int TW = 32 - IW - OW - 2;

    ICACHE_STATE   state;
    logic [LINES-1:0] vbits;
    logic [TW-1:0] tags [LINES];
    logic [TW-1:0] fill_tag;
    logic [IW-1:0] fill_idx;
    logic [OW-1:0] cnt;
    logic          poison;

    logic [OW-1:0] a_off;
    logic [IW-1:0] a_idx;
    logic [TW-1:0] a_tag;
    logic          hit, fill_we, tag_we;

    assign a_off   = address[OW+1:2];
    assign a_idx   = address[OW+IW+1:OW+2];
    assign a_tag   = address[31:OW+IW+2];
    assign hit     = vbits[a_idx] && (tags[a_idx] == a_tag);
    assign fill_we = (state == FILL) && mem_resp_valid;
    // A flush arriving in the DONE cycle must still suppress the line install.
    assign tag_we  = (state == DONE) && !poison && !flush;

    icache_line_ram #(.AW(IW + OW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (fill_we),
        .waddr ({fill_idx, cnt}),
        .wdata (mem_resp_data),
        .raddr ({a_idx, a_off}),
        .rdata (instruction)
    );

    always_ff @(posedge clk) begin
        if (tag_we)
            tags[fill_idx] <= fill_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            vbits         <= '0;
            valid         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            fill_tag      <= '0;
            fill_idx      <= '0;
            cnt           <= '0;
            poison        <= 1'b0;
`ifdef ICACHE_STATS_EN
            hit_count     <= '0;
            miss_count    <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (!flush) begin
                    if (hit) begin
                        valid <= 1'b1;
`ifdef ICACHE_STATS_EN
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
`endif
                    end else begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {a_tag, a_idx, {(OW+2){1'b0}}};
                        fill_tag      <= a_tag;
                        fill_idx      <= a_idx;
                        poison        <= 1'b0;
`ifdef ICACHE_STATS_EN
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
`endif
                    end
                end
                REQ: if (mem_req_ready) begin
                    state         <= FILL;
                    mem_req_valid <= 1'b0;
                    cnt           <= '0;
                end
                FILL: if (mem_resp_valid) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == OW'(WORDS_PER_LINE - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (tag_we)
                        vbits[fill_idx] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (flush) begin
                vbits <= '0;
                if (state == REQ || state == FILL)
                    poison <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold/conflict misses, backpressure, flush and
// reset during a fill, plus counters when ICACHE_STATS_EN is defined.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset, flush, mem_req_ready, mem_resp_valid;
    logic [31:0] address, mem_resp_data;
    logic [31:0] instruction, mem_req_addr;
    logic        valid, mem_req_valid;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .instruction    (instruction),
        .valid          (valid),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ldata(input logic [31:0] base, input int i);
        return base ^ (32'h1111_1111 * i) ^ 32'hA500_0000;
    endfunction

    function automatic logic [3:0][31:0] line_of(input logic [31:0] base);
        logic [3:0][31:0] b;
        for (int i = 0; i < 4; i++) b[i] = ldata(base, i);
        return b;
    endfunction

    // Wait (bounded) for a refill request and check its address.
    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int k = 0;
        while (!mem_req_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_req_seen"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
    endtask

    task automatic accept(input string tag);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk({tag, "_req_drop"}, {31'd0, mem_req_valid}, 32'd0);
    endtask

    task automatic beats(input logic [3:0][31:0] b, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = b[i];
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    // After the last beat: DONE cycle shows no valid, then the re-lookup hits.
    task automatic expect_hit(input string tag, input logic [31:0] exp);
        tick();
        chk({tag, "_done_nvalid"}, {31'd0, valid}, 32'd0);
        tick();
        chk({tag, "_hit_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_hit_instr"}, instruction, exp);
    endtask

    task automatic serve(input string tag, input logic [31:0] base, input logic [3:0][31:0] b);
        wait_req(tag, base);
        accept(tag);
        beats(b, 0, 3);
        expect_hit(tag, b[0]);
    endtask

    logic [3:0][31:0] line0;

    initial begin
        line0 = {32'h0030_0193, 32'h0020_0113, 32'h0010_0093, 32'h0000_0013};
        reset = 1'b1; flush = 1'b0; address = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tick(); tick();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        reset = 1'b0;

        // Cold miss at 0x0, then in-line hits with single-cycle latency.
        serve("cold", 32'h0, line0);
        address = 32'h4; tick();
        chk("hit4_valid", {31'd0, valid}, 32'd1);
        chk("hit4_instr", instruction, 32'h0010_0093);
        chk("hit4_noreq", {31'd0, mem_req_valid}, 32'd0);
        address = 32'h9; tick();
        chk("hit8_misalign", instruction, 32'h0020_0113);
        address = 32'hC; tick();
        chk("hitC_valid", {31'd0, valid}, 32'd1);
        chk("hitC_instr", instruction, 32'h0030_0193);
`ifdef ICACHE_STATS_EN
        chk("stat_hits", hit_count, 32'd4);
        chk("stat_misses", miss_count, 32'd1);
`endif

        // Conflict on index 0.
        address = 32'h100;
        serve("conf", 32'h100, line_of(32'h100));
        address = 32'h0;
        serve("conf0", 32'h0, line0);

        // Backpressure on request for 0x40.
        address = 32'h40; tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("bp_addr", mem_req_addr, 32'h40);
            tick();
        end
        accept("bp");
        beats(line_of(32'h40), 0, 3);
        expect_hit("bp", ldata(32'h40, 0));

        // Flush after the 2nd beat poisons the fill of 0x80.
        address = 32'h80;
        wait_req("fl", 32'h80);
        accept("fl");
        beats(line_of(32'h80), 0, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        beats(line_of(32'h80), 2, 3);
        tick();
        chk("fl_done_nvalid", {31'd0, valid}, 32'd0);
        tick();
        chk("fl_poison_nvalid", {31'd0, valid}, 32'd0);
        chk("fl_rereq", {31'd0, mem_req_valid}, 32'd1);
        chk("fl_rereq_addr", mem_req_addr, 32'h80);
        accept("fl2");
        beats(line_of(32'h80), 0, 3);
        expect_hit("fl2", ldata(32'h80, 0));
        address = 32'h0;
        serve("fl0", 32'h0, line0);

        // Reset in the middle of a fill of 0xC0.
        address = 32'hC0;
        wait_req("rm", 32'hC0);
        accept("rm");
        beats(line_of(32'hC0), 0, 0);
        reset = 1'b1; tick();
        chk("rm_valid", {31'd0, valid}, 32'd0);
        chk("rm_instr", instruction, 32'd0);
        chk("rm_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rm_req_addr", mem_req_addr, 32'd0);
        reset = 1'b0;
        serve("rm2", 32'hC0, line_of(32'hC0));
        address = 32'h0; tick();
        chk("rm0_nvalid", {31'd0, valid}, 32'd0);
        wait_req("rm0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
